alu_operand_stage: RTL

Parametrised, registered operand-select stage feeding one ALU input port of the multicycle datapath. It chooses one of `NUM_SRC` candidate operands (PC, register-file read, immediate, constant, forwarded result, …) and captures it into an output register with a valid/ready handshake. A one-entry skid buffer lets the ALU stall without losing an accepted operand. This replaces the old unclocked 2:1 PC/register select.

---
 rtl/alu_operand_stage.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//
// Registered operand-select stage for one ALU input port. One of NUM_SRC
// packed candidate operands is picked by src_sel and captured into a main
// output register under a valid/ready handshake. A one-entry skid register
// absorbs a second accepted operand while the ALU stalls, so in_ready can be
// a plain flop with no combinational path from out_ready.
//
// Parameters:
//   WIDTH    operand width in bits
//   NUM_SRC  number of candidate sources (>= 2)
//   SEL_W    select width, derived as $clog2(NUM_SRC); not overridable
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   src_data    packed sources, source k at [k*WIDTH +: WIDTH]
//   src_sel     source index, sampled together with in_valid
//   in_valid    select request from the control unit
//   in_ready    stage can accept (registered; high when the skid is empty)
//   op_out      operand presented to the ALU
//   op_sel_out  index that produced op_out (debug / trace)
//   out_valid   op_out is valid
//   out_ready   ALU consumes op_out
//   sel_err     sticky out-of-range select flag
//
// Build option:
//   ALU_OPERAND_SEL_CHECK_EN  when defined, an out-of-range select captures
//                             all-zero data, keeps its raw index on
//                             op_sel_out and sets sel_err until reset. When
//                             undefined, an out-of-range select is treated as
//                             source 0 and sel_err is tied low.
// ---------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int unsigned  WIDTH   = 32,
    parameter int unsigned  NUM_SRC = 4,
    localparam int unsigned SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         src_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         op_out,
    output logic [SEL_W-1:0]         op_sel_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err
);

    // -----------------------------------------------------------------------
    // State encoding: bit 1 is out_valid, bit 0 is in_ready. Both outputs are
    // therefore taken straight from state flops.
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        StEmpty = 2'b01,
        StOne   = 2'b11,
        StFull  = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic accept;
    logic consume;

    // Load enables produced by the output process
    logic main_load_in;
    logic main_load_skid;
    logic skid_load;

    // Storage
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [SEL_W-1:0] main_sel_q,  main_sel_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_sel_q,  skid_sel_d;

    // Capture path
    logic             sel_in_range;
    logic [SEL_W-1:0] cap_sel;
    logic [WIDTH-1:0] cap_data;

    assign in_ready  = state_q[0];
    assign out_valid = state_q[1];

    assign accept  = in_valid & state_q[0];
    assign consume = out_ready & state_q[1];

    assign op_out     = main_data_q;
    assign op_sel_out = main_sel_q;

    // -----------------------------------------------------------------------
    // Select range check. With a power-of-two source count every encoding is
    // legal, so the comparator is only built when holes exist.
    // -----------------------------------------------------------------------
    if ((1 << SEL_W) == NUM_SRC) begin : g_sel_full_range
        assign sel_in_range = 1'b1;
    end else begin : g_sel_partial_range
        assign sel_in_range = (32'(src_sel) < NUM_SRC);
    end

`ifdef ALU_OPERAND_SEL_CHECK_EN
    // Raw index is kept; the mux below yields zero for an index with no source.
    assign cap_sel = src_sel;
`else
    assign cap_sel = sel_in_range ? src_sel : '0;
`endif

    // Source mux written as a compare loop so an unmatched index gives zero
    // instead of an out-of-bounds part-select.
    always_comb begin
        cap_data = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (cap_sel == SEL_W'(k)) begin
                cap_data = src_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && !consume) begin
                    state_d = StFull;
                end else if (!accept && consume) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (consume) begin
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (datapath load enables)
    // -----------------------------------------------------------------------
    always_comb begin
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        unique case (state_q)
            StEmpty: begin
                main_load_in = accept;
            end
            StOne: begin
                // Simultaneous accept and consume replaces main directly;
                // accept alone parks the new operand in the skid.
                main_load_in = accept & consume;
                skid_load    = accept & ~consume;
            end
            StFull: begin
                main_load_skid = consume;
            end
            default: begin
                main_load_in   = 1'b0;
                main_load_skid = 1'b0;
                skid_load      = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next state
    // -----------------------------------------------------------------------
    always_comb begin
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;

        if (main_load_in) begin
            main_data_d = cap_data;
            main_sel_d  = cap_sel;
        end else if (main_load_skid) begin
            main_data_d = skid_data_q;
            main_sel_d  = skid_sel_q;
        end

        if (skid_load) begin
            skid_data_d = cap_data;
            skid_sel_d  = cap_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else begin
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
        end
    end

    // -----------------------------------------------------------------------
    // Out-of-range select flag
    // -----------------------------------------------------------------------
`ifdef ALU_OPERAND_SEL_CHECK_EN
    logic sel_err_q, sel_err_d;

    assign sel_err_d = sel_err_q | (accept & ~sel_in_range);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Simulation-only sanity properties
    // -----------------------------------------------------------------------
`ifndef SYNTHESIS
    // A stalled operand must not change under the ALU.
    a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> ($stable(op_out) && $stable(op_sel_out)));

    a_state_legal : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q inside {StEmpty, StOne, StFull}));
`endif

endmodule
